// File: rtl/mem_stage_dmem_if.sv
// MEM-stage data-memory bus: request fields from EX/MEM register, load result and status back.
// Latency: none (signal bundle only).
// Backpressure: MemStall from the memory side holds the EX/MEM register.
interface mem_stage_dmem_if;
    logic        MEM_MemRead;
    logic        MEM_MemWrite;
    logic [1:0]  MEM_Datatype;
    logic [31:0] MEM_ALUResult;
    logic [31:0] MEM_Data2;
    logic [31:0] MemReadData;
    logic        MemStall;
    logic        MemDone;
    logic        MemMisaligned;

    // pipeline side: drives requests, observes results
    modport master (
        output MEM_MemRead, MEM_MemWrite, MEM_Datatype, MEM_ALUResult, MEM_Data2,
        input  MemReadData, MemStall, MemDone, MemMisaligned
    );

    // memory side: observes requests, drives results
    modport slave (
        input  MEM_MemRead, MEM_MemWrite, MEM_Datatype, MEM_ALUResult, MEM_Data2,
        output MemReadData, MemStall, MemDone, MemMisaligned
    );
endinterface

// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory: word/half/byte load+store on an internal word array; optional misalign trap (DMEM_MISALIGN_TRAP_EN).
// Latency: MemDone and load data WAIT_CYCLES+1 cycles after the request is first seen.
// Backpressure: MemStall is high from request until the DONE cycle; requests are not sampled in DONE.
module mem_stage_dmem #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             Clk,
    input  logic             Clr,
    mem_stage_dmem_if.slave  bus
);
    localparam int         AW      = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [AW+1:0]   r_addr;
    logic [31:0]     r_wdat;
    logic [1:0]      r_size;
    logic            r_wr;
    logic [31:0]     r_rdata;
    logic            r_misalign;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_req;
    logic            w_is_word;
    logic            w_is_half;
    logic            w_misalign;
    logic            w_valid;
    logic            w_in_idle;
    logic            w_cap;
    logic            w_exec;
    logic [AW+1:0]   w_req_addr;
    logic [AW+1:0]   w_ex_addr;
    logic [31:0]     w_ex_wdat;
    logic [1:0]      w_ex_size;
    logic            w_ex_wr;
    logic [AW-1:0]   w_idx;
    logic [3:0]      w_be;
    logic [31:0]     w_wlane;
    logic [31:0]     w_rd_word;
    logic [31:0]     w_rd_shift;
    logic [31:0]     w_ld_val;
    logic            w_unused_addr;

    assign w_req         = bus.MEM_MemRead | bus.MEM_MemWrite;
    assign w_is_half     = (bus.MEM_Datatype == 2'b01);
    assign w_is_word     = (bus.MEM_Datatype == 2'b00) | (bus.MEM_Datatype == 2'b11);
    // upper address bits wrap around the array
    assign w_unused_addr = ^bus.MEM_ALUResult[31:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = (w_is_half & bus.MEM_ALUResult[0]) |
                        (w_is_word & (|bus.MEM_ALUResult[1:0]));
    assign w_req_addr = bus.MEM_ALUResult[AW+1:0];
`else
    // no trap: silently align the address to the access size
    assign w_misalign = 1'b0;
    assign w_req_addr = {bus.MEM_ALUResult[AW+1:2],
                         w_is_word ? 2'b00 :
                         (w_is_half ? {bus.MEM_ALUResult[1], 1'b0} : bus.MEM_ALUResult[1:0])};
`endif

    // Clr also gates the request so nothing is accepted or written while reset is held
    assign w_valid   = w_req & ~w_misalign & ~Clr;
    assign w_in_idle = (r_state == S_IDLE);
    assign w_cap     = w_in_idle & w_valid;

    // zero-wait accesses execute straight from the live inputs, otherwise from the latched copy
    assign w_ex_addr = w_in_idle ? w_req_addr           : r_addr;
    assign w_ex_wdat = w_in_idle ? bus.MEM_Data2        : r_wdat;
    assign w_ex_size = w_in_idle ? bus.MEM_Datatype     : r_size;
    assign w_ex_wr   = w_in_idle ? bus.MEM_MemWrite     : r_wr;
    assign w_exec    = (w_cap & (LP_WAIT == 4'd0)) |
                       ((r_state == S_WAIT) & (r_cnt == 4'd1) & ~Clr);

    assign w_idx      = w_ex_addr[AW+1:2];
    assign w_rd_word  = r_mem[w_idx];
    assign w_rd_shift = w_rd_word >> {w_ex_addr[1:0], 3'b000};

    // byte enables and lane-replicated store data for the selected access size
    always_comb begin
        w_be    = 4'b1111;
        w_wlane = w_ex_wdat;
        if (w_ex_size == 2'b10) begin
            w_be    = 4'b0001 << w_ex_addr[1:0];
            w_wlane = {4{w_ex_wdat[7:0]}};
        end else if (w_ex_size == 2'b01) begin
            w_be    = w_ex_addr[1] ? 4'b1100 : 4'b0011;
            w_wlane = {2{w_ex_wdat[15:0]}};
        end
    end

    // sign-extended load value for the selected lane or half
    always_comb begin
        w_ld_val = w_rd_word;
        if (w_ex_size == 2'b10) begin
            w_ld_val = {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
        end else if (w_ex_size == 2'b01) begin
            w_ld_val = {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
        end
    end

    // array write: contents survive reset, only enabled lanes change
    always_ff @(posedge Clk) begin
        if (w_exec & w_ex_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wlane[8*k +: 8];
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_valid) begin
                    w_state_nxt = (LP_WAIT == 4'd0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // request latch, wait counter, load result and misalign pulse
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_wdat     <= 32'd0;
            r_size     <= 2'b00;
            r_wr       <= 1'b0;
            r_rdata    <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_in_idle & w_req & w_misalign;
            if (w_cap) begin
                r_addr <= w_req_addr;
                r_wdat <= bus.MEM_Data2;
                r_size <= bus.MEM_Datatype;
                r_wr   <= bus.MEM_MemWrite;
                r_cnt  <= LP_WAIT;
            end else if (r_state == S_WAIT) begin
                r_cnt <= (r_cnt == 4'd1) ? 4'd0 : r_cnt - 4'd1;
            end
            if (w_exec & ~w_ex_wr) begin
                r_rdata <= w_ld_val;
            end
        end
    end

    assign bus.MemReadData   = r_rdata;
    assign bus.MemStall      = w_cap | (r_state == S_WAIT);
    assign bus.MemDone       = (r_state == S_DONE);
    assign bus.MemMisaligned = r_misalign;
endmodule

// File: tb/tb_mem_stage_dmem.sv
// Directed bench for mem_stage_dmem: WAIT_CYCLES=2 instance plus a zero-wait instance.
// Latency: checks stall/done cycle positions against hand-derived counts.
// Backpressure: bench holds each request until the DONE cycle, like a stalled pipeline.
module tb_mem_stage_dmem;
    logic Clk;
    logic Clr;
    int   n_checks;
    int   n_fail;

    mem_stage_dmem_if bus0 ();
    mem_stage_dmem_if bus1 ();

    mem_stage_dmem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut0 (.Clk(Clk), .Clr(Clr), .bus(bus0));
    mem_stage_dmem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut1 (.Clk(Clk), .Clr(Clr), .bus(bus1));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic drive(input int sel, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus0.MEM_MemRead = rd; bus0.MEM_MemWrite = wr; bus0.MEM_Datatype = sz;
            bus0.MEM_ALUResult = a; bus0.MEM_Data2 = d;
        end else begin
            bus1.MEM_MemRead = rd; bus1.MEM_MemWrite = wr; bus1.MEM_Datatype = sz;
            bus1.MEM_ALUResult = a; bus1.MEM_Data2 = d;
        end
    endtask

    // issue at a negedge, hold until DONE, report stall cycles and the cycle MemDone was seen
    task automatic access(input int sel, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d,
                          output int stalls, output int done_at);
        logic st;
        logic dn;
        @(negedge Clk);
        drive(sel, rd, wr, sz, a, d);
        stalls  = 0;
        done_at = -1;
        for (int c = 0; c < 20; c++) begin
            #1;
            st = (sel == 0) ? bus0.MemStall : bus1.MemStall;
            dn = (sel == 0) ? bus0.MemDone  : bus1.MemDone;
            if (st) stalls++;
            if (dn) begin
                done_at = c;
                break;
            end
            @(negedge Clk);
        end
        drive(sel, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        int s, d;
        Clr = 1'b1;
        drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        @(negedge Clk); #1;
        n_checks++; if (bus0.MemReadData !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=%h", bus0.MemReadData, 32'd0); end
        n_checks++; if ({bus0.MemStall, bus0.MemDone, bus0.MemMisaligned} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {bus0.MemStall, bus0.MemDone, bus0.MemMisaligned}); end
        n_checks++; if (bus1.MemReadData !== 32'd0) begin n_fail++; $display("FAIL reset_rdata1 got=%h exp=%h", bus1.MemReadData, 32'd0); end
        Clr = 1'b0;
        access(0, 1'b0, 1'b1, 2'b00, 32'h40, 32'h0BADF00D, s, d);
        n_checks++; if (d !== 3) begin n_fail++; $display("FAIL preload_done got=%0d exp=3", d); end
        // store interrupted by Clr in the middle of WAIT
        @(negedge Clk);
        drive(0, 1'b0, 1'b1, 2'b00, 32'h40, 32'hDEADBEEF);
        @(negedge Clk); #1;
        n_checks++; if (bus0.MemStall !== 1'b1) begin n_fail++; $display("FAIL midwait_stall got=%b exp=1", bus0.MemStall); end
        Clr = 1'b1;
        drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        #1;
        n_checks++; if ({bus0.MemStall, bus0.MemDone, bus0.MemMisaligned} !== 3'b000) begin n_fail++; $display("FAIL clr_flags got=%b exp=000", {bus0.MemStall, bus0.MemDone, bus0.MemMisaligned}); end
        n_checks++; if (bus0.MemReadData !== 32'd0) begin n_fail++; $display("FAIL clr_rdata got=%h exp=0", bus0.MemReadData); end
        @(negedge Clk); @(negedge Clk); #1;
        n_checks++; if (bus0.MemDone !== 1'b0) begin n_fail++; $display("FAIL clr_nodone got=%b exp=0", bus0.MemDone); end
        Clr = 1'b0;
        access(0, 1'b1, 1'b0, 2'b00, 32'h40, 32'd0, s, d);
        n_checks++; if (bus0.MemReadData !== 32'h0BADF00D) begin n_fail++; $display("FAIL clr_store_dropped got=%h exp=%h", bus0.MemReadData, 32'h0BADF00D); end
    endtask

    task automatic test_word();
        int s, d;
        access(0, 1'b0, 1'b1, 2'b00, 32'h10, 32'h12345678, s, d);
        n_checks++; if (s !== 3) begin n_fail++; $display("FAIL word_store_stall got=%0d exp=3", s); end
        n_checks++; if (d !== 3) begin n_fail++; $display("FAIL word_store_done got=%0d exp=3", d); end
        n_checks++; if (bus0.MemStall !== 1'b0) begin n_fail++; $display("FAIL word_done_stall got=%b exp=0", bus0.MemStall); end
        @(negedge Clk); #1;
        n_checks++; if (bus0.MemDone !== 1'b0) begin n_fail++; $display("FAIL done_pulse got=%b exp=0", bus0.MemDone); end
        access(0, 1'b1, 1'b0, 2'b00, 32'h10, 32'd0, s, d);
        n_checks++; if (bus0.MemReadData !== 32'h12345678) begin n_fail++; $display("FAIL word_load got=%h exp=%h", bus0.MemReadData, 32'h12345678); end
        n_checks++; if (d !== 3) begin n_fail++; $display("FAIL word_load_done got=%0d exp=3", d); end
        @(negedge Clk); @(negedge Clk); #1;
        n_checks++; if (bus0.MemReadData !== 32'h12345678) begin n_fail++; $display("FAIL rdata_hold got=%h exp=%h", bus0.MemReadData, 32'h12345678); end
    endtask

    task automatic test_byte_half();
        int s, d;
        access(0, 1'b0, 1'b1, 2'b10, 32'h13, 32'h11223380, s, d);
        access(0, 1'b1, 1'b0, 2'b00, 32'h10, 32'd0, s, d);
        n_checks++; if (bus0.MemReadData !== 32'h80345678) begin n_fail++; $display("FAIL byte_store got=%h exp=%h", bus0.MemReadData, 32'h80345678); end
        access(0, 1'b1, 1'b0, 2'b10, 32'h13, 32'd0, s, d);
        n_checks++; if (bus0.MemReadData !== 32'hFFFFFF80) begin n_fail++; $display("FAIL byte_load_sext got=%h exp=%h", bus0.MemReadData, 32'hFFFFFF80); end
        access(0, 1'b1, 1'b0, 2'b01, 32'h10, 32'd0, s, d);
        n_checks++; if (bus0.MemReadData !== 32'h00005678) begin n_fail++; $display("FAIL half_load got=%h exp=%h", bus0.MemReadData, 32'h00005678); end
        access(0, 1'b0, 1'b1, 2'b00, 32'h30, 32'h11111111, s, d);
        access(0, 1'b0, 1'b1, 2'b01, 32'h32, 32'h2222CAFE, s, d);
        access(0, 1'b1, 1'b0, 2'b00, 32'h30, 32'd0, s, d);
        n_checks++; if (bus0.MemReadData !== 32'hCAFE1111) begin n_fail++; $display("FAIL half_store got=%h exp=%h", bus0.MemReadData, 32'hCAFE1111); end
        access(0, 1'b1, 1'b0, 2'b01, 32'h32, 32'd0, s, d);
        n_checks++; if (bus0.MemReadData !== 32'hFFFFCAFE) begin n_fail++; $display("FAIL half_load_sext got=%h exp=%h", bus0.MemReadData, 32'hFFFFCAFE); end
    endtask

    task automatic test_write_priority();
        int s, d;
        access(0, 1'b1, 1'b1, 2'b00, 32'h20, 32'hA5A5A5A5, s, d);
        n_checks++; if (bus0.MemReadData !== 32'hFFFFCAFE) begin n_fail++; $display("FAIL wr_prio_rdata got=%h exp=%h", bus0.MemReadData, 32'hFFFFCAFE); end
        n_checks++; if (d !== 3) begin n_fail++; $display("FAIL wr_prio_done got=%0d exp=3", d); end
        access(0, 1'b1, 1'b0, 2'b00, 32'h20, 32'd0, s, d);
        n_checks++; if (bus0.MemReadData !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL wr_prio_mem got=%h exp=%h", bus0.MemReadData, 32'hA5A5A5A5); end
    endtask

    task automatic test_misalign();
        int s, d;
`ifdef DMEM_MISALIGN_TRAP_EN
        @(negedge Clk);
        drive(0, 1'b1, 1'b0, 2'b01, 32'h21, 32'd0);
        #1;
        n_checks++; if (bus0.MemStall !== 1'b0) begin n_fail++; $display("FAIL mis_nostall got=%b exp=0", bus0.MemStall); end
        @(negedge Clk);
        drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        #1;
        n_checks++; if (bus0.MemMisaligned !== 1'b1) begin n_fail++; $display("FAIL mis_pulse got=%b exp=1", bus0.MemMisaligned); end
        n_checks++; if (bus0.MemDone !== 1'b0) begin n_fail++; $display("FAIL mis_nodone got=%b exp=0", bus0.MemDone); end
        @(negedge Clk); #1;
        n_checks++; if (bus0.MemMisaligned !== 1'b0) begin n_fail++; $display("FAIL mis_one_cycle got=%b exp=0", bus0.MemMisaligned); end
        n_checks++; if (bus0.MemReadData !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL mis_rdata got=%h exp=%h", bus0.MemReadData, 32'hA5A5A5A5); end
        access(0, 1'b1, 1'b0, 2'b00, 32'h20, 32'd0, s, d);
        n_checks++; if (bus0.MemReadData !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL mis_mem got=%h exp=%h", bus0.MemReadData, 32'hA5A5A5A5); end
`else
        access(0, 1'b1, 1'b0, 2'b01, 32'h21, 32'd0, s, d);
        n_checks++; if (bus0.MemReadData !== 32'hFFFFA5A5) begin n_fail++; $display("FAIL unaligned_half got=%h exp=%h", bus0.MemReadData, 32'hFFFFA5A5); end
        n_checks++; if (s !== 3) begin n_fail++; $display("FAIL unaligned_stall got=%0d exp=3", s); end
        @(negedge Clk); #1;
        n_checks++; if (bus0.MemMisaligned !== 1'b0) begin n_fail++; $display("FAIL unaligned_flag got=%b exp=0", bus0.MemMisaligned); end
`endif
    endtask

    task automatic test_zero_wait_wrap();
        int s, d;
        access(1, 1'b0, 1'b1, 2'b00, 32'h1000, 32'h00000001, s, d);
        n_checks++; if (s !== 1) begin n_fail++; $display("FAIL zw_stall got=%0d exp=1", s); end
        n_checks++; if (d !== 1) begin n_fail++; $display("FAIL zw_done got=%0d exp=1", d); end
        access(1, 1'b1, 1'b0, 2'b00, 32'h0, 32'd0, s, d);
        n_checks++; if (bus1.MemReadData !== 32'h00000001) begin n_fail++; $display("FAIL zw_wrap got=%h exp=%h", bus1.MemReadData, 32'h00000001); end
        access(1, 1'b0, 1'b1, 2'b10, 32'h1002, 32'h000000F0, s, d);
        access(1, 1'b1, 1'b0, 2'b00, 32'h0, 32'd0, s, d);
        n_checks++; if (bus1.MemReadData !== 32'h00F00001) begin n_fail++; $display("FAIL zw_byte got=%h exp=%h", bus1.MemReadData, 32'h00F00001); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_word();
        test_byte_half();
        test_write_priority();
        test_misalign();
        test_zero_wait_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
